riscv_multicycle_cpu: RTL and testbench

Multi-cycle RV32I core: the successor to the single-cycle CPU. Fetch, load and store share one memory port with a ready handshake, so the core tolerates wait-state memories and a single unified instruction/data RAM. It executes the same instruction set as the single-cycle core: lw, sw, R-type ALU, I-type ALU, all six branches, jal, jalr, lui and auipc. It sits between the top-level wrapper and a shared memory.

---
 rtl/riscv_multicycle_cpu.sv | 267 ++++++++++++++++++++++++++
 tb/tb_riscv_multicycle_cpu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_cpu.sv
// Multi-cycle RV32I core sharing one memory port for fetch, load and store (ready handshake).
// Optional feature: define RISCV_TRAP_EN for illegal/misaligned traps and the HALT state.
module riscv_multicycle_cpu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          REG_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Result,
  output logic        retire,
  output logic        trap
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef RISCV_TRAP_EN
    , HALT
`endif
  } state_t;

  state_t      state;
  logic [31:0] ir, a, b, t, alu_out, mdr;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, op2, alu_res, exec_val, wb_val, jalr_target, pc_plus4;
  logic        take, known, exec_fault;

  assign opcode      = ir[6:0];
  assign rd          = ir[11:7];
  assign funct3      = ir[14:12];
  assign rs1         = ir[19:15];
  assign rs2         = ir[24:20];
  assign pc_plus4    = PC + 32'd4;
  assign op2         = (opcode == OP_REG) ? b : imm;
  assign jalr_target = (a + imm) & ~32'h1;
  assign wb_val      = (opcode == OP_LOAD) ? mdr : alu_out;

  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                 imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {ir[31:12], 12'b0};
      OP_JAL:                   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

  // ir[30] selects sub only for register ops; for shifts it selects arithmetic right shift.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (opcode == OP_REG && ir[30]) ? a - op2 : a + op2;
      3'b001:  alu_res = a << op2[4:0];
      3'b010:  alu_res = {31'b0, $signed(a) < $signed(op2)};
      3'b011:  alu_res = {31'b0, a < op2};
      3'b100:  alu_res = a ^ op2;
      3'b101:  alu_res = ir[30] ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
      3'b110:  alu_res = a | op2;
      default: alu_res = a & op2;
    endcase
  end

  always_comb begin
    exec_val = '0;
    known    = 1'b1;
    case (opcode)
      OP_REG, OP_IMM:     exec_val = alu_res;
      OP_LUI:             exec_val = imm;
      OP_AUIPC:           exec_val = PC + imm;
      OP_JAL, OP_JALR:    exec_val = pc_plus4;
      OP_LOAD, OP_STORE:  exec_val = a + imm;
      OP_BRANCH:          exec_val = a - b;
      default:            known    = 1'b0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = (a == b);
      3'b001:  take = (a != b);
      3'b100:  take = ($signed(a) < $signed(b));
      3'b101:  take = ($signed(a) >= $signed(b));
      3'b110:  take = (a < b);
      3'b111:  take = (a >= b);
      default: take = 1'b0;
    endcase
  end

`ifdef RISCV_TRAP_EN
  logic legal;

  always_comb begin
    legal = 1'b1;
    case (opcode)
      OP_REG:            legal = (ir[31:25] == 7'h00) ||
                                 (ir[31:25] == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      OP_IMM:            if (funct3 == 3'b001)
                           legal = (ir[31:25] == 7'h00);
                         else if (funct3 == 3'b101)
                           legal = (ir[31:25] == 7'h00) || (ir[31:25] == 7'h20);
      OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
      OP_BRANCH:         legal = (funct3[2:1] != 2'b01);
      OP_JALR:           legal = (funct3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  end

  always_comb begin
    exec_fault = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: exec_fault = (exec_val[1:0] != 2'b00);
      OP_BRANCH:         exec_fault = take && t[1];
      OP_JAL:            exec_fault = t[1];
      OP_JALR:           exec_fault = jalr_target[1];
      default:           exec_fault = 1'b0;
    endcase
  end
`else
  assign exec_fault = 1'b0;
  assign trap       = 1'b0;
`endif

  // Port outputs decode straight from state so the first fetch appears as soon as reset drops.
  assign mem_req   = !reset && (state == FETCH || state == MEM);
  assign mem_we    = !reset && (state == MEM) && (opcode == OP_STORE);
  assign mem_addr  = (state == MEM) ? {alu_out[31:2], 2'b00} : {PC[31:2], 2'b00};
  assign mem_wdata = (state == MEM && opcode == OP_STORE) ? b : '0;

  always_comb begin
    retire = 1'b0;
    if (!reset) begin
      case (state)
        WB:      retire = 1'b1;
        EXEC:    retire = (opcode == OP_BRANCH || !known) && !exec_fault;
        MEM:     retire = mem_ready && (opcode == OP_STORE);
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (REG_RESET)
        for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (state == WB && rd != 5'd0) begin
      regs[rd] <= wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      PC      <= RESET_PC;
      Result  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      t       <= '0;
      alu_out <= '0;
      mdr     <= '0;
`ifdef RISCV_TRAP_EN
      trap    <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          state <= DECODE;
        end
        DECODE: begin
          a     <= (rs1 == 5'd0) ? '0 : regs[rs1];
          b     <= (rs2 == 5'd0) ? '0 : regs[rs2];
          t     <= PC + imm;
          state <= EXEC;
`ifdef RISCV_TRAP_EN
          if (!legal) begin
            trap  <= 1'b1;
            state <= HALT;
          end
`endif
        end
        EXEC: begin
          alu_out <= exec_val;
          case (opcode)
            OP_LOAD, OP_STORE: state <= MEM;
            OP_BRANCH: begin
              PC     <= take ? t : pc_plus4;
              Result <= exec_val;
              state  <= FETCH;
            end
            OP_JAL: begin
              PC    <= t;
              state <= WB;
            end
            OP_JALR: begin
              PC    <= jalr_target;
              state <= WB;
            end
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC: state <= WB;
            default: begin
              PC    <= pc_plus4;
              state <= FETCH;
            end
          endcase
`ifdef RISCV_TRAP_EN
          // A fault leaves PC on the offending instruction and commits nothing.
          if (exec_fault) begin
            PC     <= PC;
            Result <= Result;
            trap   <= 1'b1;
            state  <= HALT;
          end
`endif
        end
        MEM: if (mem_ready) begin
          if (opcode == OP_STORE) begin
            PC     <= pc_plus4;
            Result <= alu_out;
            state  <= FETCH;
          end else begin
            mdr   <= mem_rdata;
            state <= WB;
          end
        end
        WB: begin
          Result <= wb_val;
          if (opcode != OP_JAL && opcode != OP_JALR)
            PC <= pc_plus4;
          state <= FETCH;
        end
`ifdef RISCV_TRAP_EN
        HALT: state <= HALT;
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_cpu.sv
// Scoreboard bench for riscv_multicycle_cpu: a directed program runs from a wait-state memory
// model; expected retirements are queued at load time and checked by a monitor on each retire.
`timescale 1ns/1ps
module tb_riscv_multicycle_cpu;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] res;
    bit          chk_res;
    int          cycles;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PC, Result;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:7];
  int          wait_cnt;
  logic        slow;
  logic        hold_v;
  logic [33:0] hold_ctl;
  logic [31:0] hold_wdata;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  exp_t        cur;
  bit          pend = 1'b0;
  bit          mon_on = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  riscv_multicycle_cpu #(.RESET_PC(32'h0000_0100), .REG_RESET(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .PC        (PC),
    .Result    (Result),
    .retire    (retire),
    .trap      (trap)
  );

  // The sw/lw fetches and their data word each see two wait states.
  assign slow      = (mem_addr == 32'h114) || (mem_addr == 32'h118) || (mem_addr == 32'h8);
  assign mem_ready = mem_req && (wait_cnt >= (slow ? 2 : 0));
  assign mem_rdata = (mem_addr < 32'h20) ? dmem[mem_addr[4:2]] : imem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ready) wait_cnt <= 0;
    else                                wait_cnt <= wait_cnt + 1;
    hold_v     <= !reset && mem_req && !mem_ready;
    hold_ctl   <= {mem_req, mem_we, mem_addr};
    hold_wdata <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] instr, input string name,
                               input logic [31:0] pc_next, input logic [31:0] res,
                               input bit chk_res, input int cycles);
    exp_t e;
    imem[addr[9:2]] = instr;
    e.name = name; e.pc = pc_next; e.res = res; e.chk_res = chk_res; e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Handshake stability: a request left waiting must reappear unchanged the next cycle.
  always @(negedge clk) begin
    if (hold_v && !reset) begin
      checkOutput("hold_ctl", {30'b0, mem_req, mem_we, mem_addr}, {30'b0, hold_ctl});
      checkOutput("hold_wdata", {32'b0, mem_wdata}, {32'b0, hold_wdata});
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) dmem[i] = '0;
    end else if (mem_req && mem_we && mem_ready) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_store: got addr %0h data %0h, required no store", mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        checkOutput("store_addr", {32'b0, mem_addr}, {32'b0, w.addr});
        checkOutput("store_data", {32'b0, mem_wdata}, {32'b0, w.data});
      end
      dmem[mem_addr[4:2]] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      cyc  = 0;
      pend = 1'b0;
    end else if (mon_on) begin
      if (pend) begin
        checkOutput({cur.name, "_pc"}, {32'b0, PC}, {32'b0, cur.pc});
        if (cur.chk_res) checkOutput({cur.name, "_result"}, {32'b0, Result}, {32'b0, cur.res});
        pend = 1'b0;
      end
      cyc++;
      if (retire) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_retire: got retire at PC %0h, required none", PC);
        end else begin
          cur = exp_q.pop_front();
          checkOutput({cur.name, "_cycles"}, 64'(cyc), 64'(cur.cycles));
          pend = 1'b1;
        end
        cyc = 0;
      end
    end
  end

  initial begin
    wr_t w;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;

    applyStimulus(32'h100, enc_r(7'h00, 5'd18, 5'd17, 3'b000, 5'd16), "add_reset_regs", 32'h104, 32'h0, 1, 4);
    applyStimulus(32'h104, enc_i(32'd5, 5'd0, 3'b000, 5'd1, OP_IMM), "addi_x1", 32'h108, 32'h5, 1, 4);
    applyStimulus(32'h108, enc_i(-32'sd3, 5'd0, 3'b000, 5'd2, OP_IMM), "addi_x2", 32'h10C, 32'hFFFF_FFFD, 1, 4);
    applyStimulus(32'h10C, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), "add_x3", 32'h110, 32'h2, 1, 4);
    applyStimulus(32'h110, enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4), "sub_x4", 32'h114, 32'hFFFF_FFF8, 1, 4);
    applyStimulus(32'h114, enc_s(32'd8, 5'd3, 5'd0), "sw_x3", 32'h118, 32'h8, 1, 8);
    applyStimulus(32'h118, enc_i(32'd8, 5'd0, 3'b010, 5'd5, OP_LOAD), "lw_x5", 32'h11C, 32'h2, 1, 9);
    applyStimulus(32'h11C, enc_b(32'd8, 5'd1, 5'd2, 3'b100), "blt_taken", 32'h124, 32'h0, 0, 3);
    imem[32'h120 >> 2] = enc_i(32'd1, 5'd0, 3'b000, 5'd31, OP_IMM);
    applyStimulus(32'h124, enc_b(32'd8, 5'd1, 5'd2, 3'b110), "bltu_not_taken", 32'h128, 32'h0, 0, 3);
    applyStimulus(32'h128, enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), "add_x6_from_x5", 32'h12C, 32'h2, 1, 4);
    applyStimulus(32'h12C, enc_i(32'h20, 5'd0, 3'b000, 5'd7, OP_IMM), "addi_x7", 32'h130, 32'h20, 1, 4);
    applyStimulus(32'h130, enc_i(32'd0, 5'd7, 3'b000, 5'd0, OP_JALR), "jalr_to_20", 32'h20, 32'h134, 1, 4);
    applyStimulus(32'h020, enc_j(32'd16, 5'd1), "jal_x1", 32'h30, 32'h24, 1, 4);
    applyStimulus(32'h030, enc_i(32'd1, 5'd1, 3'b000, 5'd0, OP_JALR), "jalr_odd", 32'h24, 32'h34, 1, 4);
    applyStimulus(32'h024, enc_j(32'h40, 5'd0), "jal_x0", 32'h64, 32'h28, 1, 4);
    applyStimulus(32'h064, {20'h12345, 5'd8, OP_LUI}, "lui_x8", 32'h68, 32'h1234_5000, 1, 4);
    applyStimulus(32'h068, {20'h00001, 5'd9, OP_AUIPC}, "auipc_x9", 32'h6C, 32'h0000_1068, 1, 4);
    applyStimulus(32'h06C, enc_i(-32'sd16, 5'd0, 3'b000, 5'd10, OP_IMM), "addi_x10", 32'h70, 32'hFFFF_FFF0, 1, 4);
    applyStimulus(32'h070, enc_i(32'h402, 5'd10, 3'b101, 5'd11, OP_IMM), "srai_x11", 32'h74, 32'hFFFF_FFFC, 1, 4);
    applyStimulus(32'h074, enc_i(32'd28, 5'd10, 3'b101, 5'd12, OP_IMM), "srli_x12", 32'h78, 32'h0000_000F, 1, 4);
    applyStimulus(32'h078, enc_r(7'h00, 5'd10, 5'd0, 3'b011, 5'd13), "sltu_x13", 32'h7C, 32'h1, 1, 4);
    applyStimulus(32'h07C, enc_i(32'd7, 5'd0, 3'b000, 5'd0, OP_IMM), "addi_x0", 32'h80, 32'h7, 1, 4);
    applyStimulus(32'h080, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd14), "add_x0_reads_0", 32'h84, 32'h0, 1, 4);
    applyStimulus(32'h084, enc_r(7'h00, 5'd8, 5'd10, 3'b100, 5'd15), "xor_x15", 32'h88, 32'hEDCB_AFF0, 1, 4);
`ifdef RISCV_TRAP_EN
    imem[32'h88 >> 2] = 32'h0000_007F;
`else
    applyStimulus(32'h088, 32'h0000_007F, "unknown_nop", 32'h8C, 32'h0, 0, 3);
    applyStimulus(32'h08C, enc_b(32'd0, 5'd0, 5'd0, 3'b000), "beq_self", 32'h8C, 32'h0, 0, 3);
`endif
    w.addr = 32'h8;
    w.data = 32'h2;
    wr_q.push_back(w);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pc", {32'b0, PC}, 64'h100);
    checkOutput("reset_result", {32'b0, Result}, 64'h0);
    checkOutput("reset_mem_req", {63'b0, mem_req}, 64'h0);
    checkOutput("reset_mem_we", {63'b0, mem_we}, 64'h0);
    checkOutput("reset_mem_wdata", {32'b0, mem_wdata}, 64'h0);
    checkOutput("reset_retire", {63'b0, retire}, 64'h0);
    checkOutput("reset_trap", {63'b0, trap}, 64'h0);

    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("first_req", {63'b0, mem_req}, 64'h1);
    checkOutput("first_addr", {32'b0, mem_addr}, 64'h100);

    for (int i = 0; i < 800 && (exp_q.size() != 0 || pend); i++) @(negedge clk);
    if (exp_q.size() != 0 || pend) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL retire_timeout: got %0d retirements outstanding, required 0", exp_q.size());
    end
    checkOutput("store_count", 64'(wr_q.size()), 64'h0);
    checkOutput("stored_word", {32'b0, dmem[2]}, 64'h2);

`ifdef RISCV_TRAP_EN
    for (int i = 0; i < 20 && trap !== 1'b1; i++) @(negedge clk);
    checkOutput("trap_set", {63'b0, trap}, 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("halt_mem_req", {63'b0, mem_req}, 64'h0);
      checkOutput("halt_pc", {32'b0, PC}, 64'h88);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("trap_cleared", {63'b0, trap}, 64'h0);
    checkOutput("reset_pc_again", {32'b0, PC}, 64'h100);
`else
    mon_on = 1'b0;
    checkOutput("trap_tied_low", {63'b0, trap}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
